// File: rtl/tri_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tri_pkg
// Brief   : Shared widths, FSM state encoding and inside-test helper for the
//           triangle raster scanner.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
package tri_pkg;

    localparam int TRI_COORD_W = 11;
    localparam int EDGE_W      = 2*TRI_COORD_W + 3;
    localparam int CNT_W       = 2*TRI_COORD_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SCAN  = 2'd2,
        ST_DONE  = 2'd3
    } tri_state_t;

    // pos[i] = Ei > 0, neg[i] = Ei < 0; inclusive mode accepts zero on any edge
    function automatic logic tri_is_inside(input logic [2:0] pos,
                                           input logic [2:0] neg,
                                           input logic       incl);
        if (incl) begin
            return (neg == 3'b000) || (pos == 3'b000);
        end
        return (pos == 3'b111) || (neg == 3'b111);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tri_edge_eval.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tri_edge_eval
// Brief   : Combinational edge function E(a,b,p) at full precision.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tri_edge_eval #(
    parameter int COORD_W = 11
) (
    input  logic [COORD_W-1:0]          ax,
    input  logic [COORD_W-1:0]          ay,
    input  logic [COORD_W-1:0]          bx,
    input  logic [COORD_W-1:0]          by,
    input  logic [COORD_W-1:0]          px,
    input  logic [COORD_W-1:0]          py,
    output logic signed [2*COORD_W+2:0] e
);

    localparam int D_W = COORD_W + 1;
    localparam int P_W = 2*COORD_W + 2;

    logic signed [D_W-1:0] w_dbx, w_dby, w_dpx, w_dpy;
    logic signed [P_W-1:0] w_dbx_x, w_dby_x, w_dpx_x, w_dpy_x;
    logic signed [P_W-1:0] w_m1, w_m2;

    assign w_dbx = $signed({1'b0, bx}) - $signed({1'b0, ax});
    assign w_dby = $signed({1'b0, by}) - $signed({1'b0, ay});
    assign w_dpx = $signed({1'b0, px}) - $signed({1'b0, ax});
    assign w_dpy = $signed({1'b0, py}) - $signed({1'b0, ay});

    assign w_dbx_x = {{(P_W-D_W){w_dbx[D_W-1]}}, w_dbx};
    assign w_dby_x = {{(P_W-D_W){w_dby[D_W-1]}}, w_dby};
    assign w_dpx_x = {{(P_W-D_W){w_dpx[D_W-1]}}, w_dpx};
    assign w_dpy_x = {{(P_W-D_W){w_dpy[D_W-1]}}, w_dpy};

    assign w_m1 = w_dbx_x * w_dpy_x;
    assign w_m2 = w_dby_x * w_dpx_x;

    // one extra bit so the difference of two full-range products cannot overflow
    assign e = {w_m1[P_W-1], w_m1} - {w_m2[P_W-1], w_m2};

endmodule
`default_nettype wire

// File: rtl/tri_raster_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tri_raster_scan
// Brief   : Streaming triangle rasteriser; scans the bounding box row-major
//           and emits pixels with an inside flag over valid/ready.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tri_raster_scan import tri_pkg::*; #(
    parameter int COORD_W   = TRI_COORD_W,
    parameter bit EDGE_INCL = 1'b0,
    parameter bit EMIT_ALL  = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [COORD_W-1:0]   p1x,
    input  logic [COORD_W-1:0]   p1y,
    input  logic [COORD_W-1:0]   p2x,
    input  logic [COORD_W-1:0]   p2y,
    input  logic [COORD_W-1:0]   p3x,
    input  logic [COORD_W-1:0]   p3y,
    output logic                 busy,
    output logic                 done,
    output logic                 degenerate,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic [COORD_W-1:0]   pix_x,
    output logic [COORD_W-1:0]   pix_y,
    output logic                 pix_inside,
    output logic [2*COORD_W:0]   inside_cnt
);

    localparam int SCAN_EDGE_W = 2*COORD_W + 3;
    localparam int SCAN_CNT_W  = 2*COORD_W + 1;
    localparam logic [COORD_W-1:0]    c_one_xy  = {{(COORD_W-1){1'b0}}, 1'b1};
    localparam logic [SCAN_CNT_W-1:0] c_one_cnt = {{(SCAN_CNT_W-1){1'b0}}, 1'b1};

    tri_state_t r_state, w_state_nxt;

    logic [COORD_W-1:0] r_v1x, r_v1y, r_v2x, r_v2y, r_v3x, r_v3y;
    logic [COORD_W-1:0] r_xmin, r_xmax, r_ymax;
    logic [COORD_W-1:0] w_xmin, w_xmax, w_ymin, w_ymax;
    logic [COORD_W-1:0] r_cur_x, r_cur_y;
    logic [COORD_W-1:0] w_e1_px, w_e1_py;
    logic [SCAN_CNT_W-1:0] r_cnt;
    logic r_degen;

    logic signed [SCAN_EDGE_W-1:0] w_e1, w_e2, w_e3;
    logic [2:0] w_pos, w_neg;
    logic w_inside, w_scan, w_fire, w_adv, w_row_end, w_last, w_start_acc, w_zero_area;

    always_comb begin
        w_xmin = r_v1x;
        w_xmax = r_v1x;
        w_ymin = r_v1y;
        w_ymax = r_v1y;
        if (r_v2x < w_xmin) w_xmin = r_v2x;
        if (r_v3x < w_xmin) w_xmin = r_v3x;
        if (r_v2x > w_xmax) w_xmax = r_v2x;
        if (r_v3x > w_xmax) w_xmax = r_v3x;
        if (r_v2y < w_ymin) w_ymin = r_v2y;
        if (r_v3y < w_ymin) w_ymin = r_v3y;
        if (r_v2y > w_ymax) w_ymax = r_v2y;
        if (r_v3y > w_ymax) w_ymax = r_v3y;
    end

    // During SETUP the first evaluator sees v3, so its result is the signed area
    assign w_e1_px = (r_state == ST_SETUP) ? r_v3x : r_cur_x;
    assign w_e1_py = (r_state == ST_SETUP) ? r_v3y : r_cur_y;

    tri_edge_eval #(.COORD_W(COORD_W)) u_edge1 (
        .ax(r_v1x), .ay(r_v1y), .bx(r_v2x), .by(r_v2y),
        .px(w_e1_px), .py(w_e1_py), .e(w_e1)
    );
    tri_edge_eval #(.COORD_W(COORD_W)) u_edge2 (
        .ax(r_v2x), .ay(r_v2y), .bx(r_v3x), .by(r_v3y),
        .px(r_cur_x), .py(r_cur_y), .e(w_e2)
    );
    tri_edge_eval #(.COORD_W(COORD_W)) u_edge3 (
        .ax(r_v3x), .ay(r_v3y), .bx(r_v1x), .by(r_v1y),
        .px(r_cur_x), .py(r_cur_y), .e(w_e3)
    );

    assign w_neg = {w_e3[SCAN_EDGE_W-1], w_e2[SCAN_EDGE_W-1], w_e1[SCAN_EDGE_W-1]};
    assign w_pos = {!w_e3[SCAN_EDGE_W-1] && (w_e3 != '0),
                    !w_e2[SCAN_EDGE_W-1] && (w_e2 != '0),
                    !w_e1[SCAN_EDGE_W-1] && (w_e1 != '0)};
    assign w_inside    = tri_is_inside(w_pos, w_neg, EDGE_INCL);
    assign w_zero_area = (w_e1 == '0);

    assign w_scan      = (r_state == ST_SCAN);
    assign w_fire      = pix_valid && pix_ready;
    // outside pixels are consumed internally when only inside pixels are streamed
    assign w_adv       = w_scan && (w_fire || (!EMIT_ALL && !w_inside));
    assign w_row_end   = (r_cur_x == r_xmax);
    assign w_last      = w_row_end && (r_cur_y == r_ymax);
    assign w_start_acc = (r_state == ST_IDLE) && start && !abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_state_nxt = ST_SETUP;
            ST_SETUP: w_state_nxt = w_zero_area ? ST_DONE : ST_SCAN;
            ST_SCAN:  if (w_adv && w_last) w_state_nxt = ST_DONE;
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1x   <= '0; r_v1y <= '0;
            r_v2x   <= '0; r_v2y <= '0;
            r_v3x   <= '0; r_v3y <= '0;
            r_xmin  <= '0; r_xmax <= '0; r_ymax <= '0;
            r_cur_x <= '0; r_cur_y <= '0;
            r_cnt   <= '0;
            r_degen <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_v1x <= p1x; r_v1y <= p1y;
                r_v2x <= p2x; r_v2y <= p2y;
                r_v3x <= p3x; r_v3y <= p3y;
                r_cnt <= '0;
            end
            if ((r_state == ST_SETUP) && !abort) begin
                r_xmin  <= w_xmin;
                r_xmax  <= w_xmax;
                r_ymax  <= w_ymax;
                r_cur_x <= w_xmin;
                r_cur_y <= w_ymin;
                r_degen <= w_zero_area;
            end
            // last-pixel test precedes the increment so counters never wrap at max coordinate
            if (w_adv && !abort) begin
                if (w_inside) r_cnt <= r_cnt + c_one_cnt;
                if (!w_last) begin
                    if (w_row_end) begin
                        r_cur_x <= r_xmin;
                        r_cur_y <= r_cur_y + c_one_xy;
                    end else begin
                        r_cur_x <= r_cur_x + c_one_xy;
                    end
                end
            end
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign degenerate = r_degen;
    assign pix_valid  = w_scan && (EMIT_ALL || w_inside);
    assign pix_inside = w_scan && w_inside;
    assign pix_x      = r_cur_x;
    assign pix_y      = r_cur_y;
    assign inside_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tri_raster_scan.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_tri_raster_scan
// Brief   : Directed self-checking bench; three instances (strict, inclusive,
//           strict inside-only) share the stimulus.
// Revision: 1.0  initial release
// ---------------------------------------------------------------------------
module tb_tri_raster_scan;

    localparam int CW     = 11;
    localparam int MAXCYC = 3000;

    logic clk = 1'b0;
    logic reset, start, abort, pix_ready;
    logic [CW-1:0] p1x, p1y, p2x, p2y, p3x, p3y;
    logic [2:0] busy, done, degen, pv, pin;
    logic [CW-1:0] px [3];
    logic [CW-1:0] py [3];
    logic [2*CW:0] icnt [3];

    int errors = 0;
    int checks = 0;

    int n_hs[3], n_in[3], hs_last[3], done_cyc[3], done_w[3];
    int first_v[3], first_x[3], first_y[3], ord_err[3], stab_err[3], last_key[3];
    int seen [3][32][32];
    logic ins_map [3][32][32];
    logic prev_v[3], prev_in[3];
    logic [CW-1:0] prev_x[3], prev_y[3];
    logic prev_r;

    always #5 clk = ~clk;

    tri_raster_scan #(.COORD_W(CW), .EDGE_INCL(1'b0), .EMIT_ALL(1'b1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .busy(busy[0]), .done(done[0]), .degenerate(degen[0]), .pix_valid(pv[0]),
        .pix_ready(pix_ready), .pix_x(px[0]), .pix_y(py[0]), .pix_inside(pin[0]),
        .inside_cnt(icnt[0])
    );
    tri_raster_scan #(.COORD_W(CW), .EDGE_INCL(1'b1), .EMIT_ALL(1'b1)) dut_i (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .busy(busy[1]), .done(done[1]), .degenerate(degen[1]), .pix_valid(pv[1]),
        .pix_ready(pix_ready), .pix_x(px[1]), .pix_y(py[1]), .pix_inside(pin[1]),
        .inside_cnt(icnt[1])
    );
    tri_raster_scan #(.COORD_W(CW), .EDGE_INCL(1'b0), .EMIT_ALL(1'b0)) dut_e (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y),
        .busy(busy[2]), .done(done[2]), .degenerate(degen[2]), .pix_valid(pv[2]),
        .pix_ready(pix_ready), .pix_x(px[2]), .pix_y(py[2]), .pix_inside(pin[2]),
        .inside_cnt(icnt[2])
    );

    task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                           input int cx, input int cy);
        p1x = CW'(ax); p1y = CW'(ay);
        p2x = CW'(bx); p2y = CW'(by);
        p3x = CW'(cx); p3y = CW'(cy);
    endtask

    // Starts a triangle at cycle 0 and records the pixel stream of all three instances
    task automatic run_scan(input int stall_from, input int stall_len);
        bit fin = 1'b0;
        int xi, yi, key;
        for (int k = 0; k < 3; k++) begin
            n_hs[k] = 0; n_in[k] = 0; hs_last[k] = -1; done_cyc[k] = -1; done_w[k] = 0;
            first_v[k] = -1; first_x[k] = -1; first_y[k] = -1;
            ord_err[k] = 0; stab_err[k] = 0; last_key[k] = -1; prev_v[k] = 1'b0;
            for (int x = 0; x < 32; x++)
                for (int y = 0; y < 32; y++) begin
                    seen[k][x][y] = 0;
                    ins_map[k][x][y] = 1'b0;
                end
        end
        prev_r = 1'b1;
        for (int i = 0; i < MAXCYC && !fin; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (prev_v[k] && !prev_r &&
                    (pv[k] !== 1'b1 || px[k] !== prev_x[k] || py[k] !== prev_y[k] || pin[k] !== prev_in[k]))
                    stab_err[k]++;
                if (done[k] === 1'b1) begin
                    done_w[k]++;
                    if (done_cyc[k] < 0) done_cyc[k] = i;
                end
                if (pv[k] === 1'b1 && first_v[k] < 0) begin
                    first_v[k] = i; first_x[k] = int'(px[k]); first_y[k] = int'(py[k]);
                end
            end
            pix_ready = !(i >= stall_from && i < stall_from + stall_len);
            start     = (i == 0);
            for (int k = 0; k < 3; k++) begin
                if (pv[k] === 1'b1 && pix_ready) begin
                    n_hs[k]++;
                    if (pin[k] === 1'b1) n_in[k]++;
                    hs_last[k] = i;
                    xi = int'(px[k]); yi = int'(py[k]);
                    key = yi * 4096 + xi;
                    if (key <= last_key[k]) ord_err[k]++;
                    last_key[k] = key;
                    if (xi < 32 && yi < 32) begin
                        seen[k][xi][yi]++;
                        ins_map[k][xi][yi] = pin[k];
                    end
                end
                prev_v[k] = pv[k]; prev_x[k] = px[k]; prev_y[k] = py[k]; prev_in[k] = pin[k];
            end
            prev_r = pix_ready;
            if (i >= 2 && busy === 3'b000) fin = 1'b1;
        end
        start = 1'b0;
        pix_ready = 1'b1;
        checks++; if (!fin) begin errors++; $display("FAIL scan_timeout: busy=%b, required 000 within %0d cycles", busy, MAXCYC); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
        set_tri(0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({busy[k], done[k], degen[k], pv[k], pin[k], px[k], py[k], icnt[k]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d: busy=%b done=%b degen=%b valid=%b in=%b x=%0d y=%0d cnt=%0d, required all 0",
                         k, busy[k], done[k], degen[k], pv[k], pin[k], px[k], py[k], icnt[k]);
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_right_triangle();
        int bad = 0;
        set_tri(0, 0, 10, 0, 0, 10);
        run_scan(MAXCYC, 0);
        for (int x = 0; x <= 10; x++)
            for (int y = 0; y <= 10; y++)
                if (seen[0][x][y] != 1 || seen[1][x][y] != 1) bad++;
        checks++; if (n_hs[0] !== 121) begin errors++; $display("FAIL t1_pixels: got %0d required 121", n_hs[0]); end
        checks++; if (icnt[0] !== 36) begin errors++; $display("FAIL t1_inside_cnt: got %0d required 36", icnt[0]); end
        checks++; if (n_in[0] !== 36) begin errors++; $display("FAIL t1_inside_flags: got %0d required 36", n_in[0]); end
        checks++; if (ins_map[0][3][3] !== 1'b1) begin errors++; $display("FAIL t1_pix33: got %b required 1", ins_map[0][3][3]); end
        checks++; if (ins_map[0][10][0] !== 1'b0) begin errors++; $display("FAIL t1_strict_vertex: got %b required 0", ins_map[0][10][0]); end
        checks++; if (first_v[0] !== 2) begin errors++; $display("FAIL t1_latency: first valid cycle %0d required 2", first_v[0]); end
        checks++; if (done_cyc[0] !== hs_last[0] + 1) begin errors++; $display("FAIL t1_done_time: got %0d required %0d", done_cyc[0], hs_last[0] + 1); end
        checks++; if (done_w[0] !== 1) begin errors++; $display("FAIL t1_done_width: got %0d required 1", done_w[0]); end
        checks++; if (ord_err[0] + ord_err[1] !== 0) begin errors++; $display("FAIL t1_order: got %0d errors required 0", ord_err[0] + ord_err[1]); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL t1_coverage: got %0d bad pixels required 0", bad); end
        checks++; if (icnt[1] !== 66) begin errors++; $display("FAIL t2_inside_cnt: got %0d required 66", icnt[1]); end
        checks++; if (ins_map[1][10][0] !== 1'b1 || ins_map[1][0][5] !== 1'b1) begin
            errors++; $display("FAIL t2_edge_pixels: got %b%b required 11", ins_map[1][10][0], ins_map[1][0][5]); end
        checks++; if (n_hs[2] !== 36 || n_in[2] !== 36) begin errors++; $display("FAIL t1_inside_only: got %0d/%0d required 36/36", n_hs[2], n_in[2]); end
    endtask

    task automatic test_offset_triangle();
        for (int r = 0; r < 2; r++) begin
            if (r == 0) set_tri(15, 15, 30, 0, 15, 0);
            else        set_tri(15, 0, 30, 0, 15, 15);
            run_scan(MAXCYC, 0);
            checks++; if (icnt[0] !== 91) begin errors++; $display("FAIL t3_strict_cnt order%0d: got %0d required 91", r, icnt[0]); end
            checks++; if (icnt[1] !== 136) begin errors++; $display("FAIL t3_incl_cnt order%0d: got %0d required 136", r, icnt[1]); end
            checks++; if (n_hs[0] !== 256) begin errors++; $display("FAIL t3_pixels order%0d: got %0d required 256", r, n_hs[0]); end
            checks++; if (n_hs[2] !== 91 || icnt[2] !== 91) begin errors++; $display("FAIL t3_inside_only order%0d: got %0d/%0d required 91/91", r, n_hs[2], icnt[2]); end
            checks++; if (seen[0][3][3] !== 0) begin errors++; $display("FAIL t3_pix33_emitted order%0d: got %0d required 0", r, seen[0][3][3]); end
            checks++; if (first_x[0] !== 15 || first_y[0] !== 0) begin errors++; $display("FAIL t3_first_pixel order%0d: got (%0d,%0d) required (15,0)", r, first_x[0], first_y[0]); end
        end
    endtask

    task automatic test_degenerate();
        set_tri(0, 0, 5, 5, 10, 10);
        run_scan(MAXCYC, 0);
        checks++; if (first_v[0] !== -1 || first_v[1] !== -1 || first_v[2] !== -1) begin
            errors++; $display("FAIL t4_no_valid: got cycles %0d %0d %0d required -1", first_v[0], first_v[1], first_v[2]); end
        checks++; if (degen !== 3'b111) begin errors++; $display("FAIL t4_degenerate: got %b required 111", degen); end
        checks++; if (done_cyc[0] !== 2) begin errors++; $display("FAIL t4_done_time: got %0d required 2", done_cyc[0]); end
        checks++; if (icnt[0] !== 0) begin errors++; $display("FAIL t4_cnt_cleared: got %0d required 0", icnt[0]); end
    endtask

    task automatic test_stall();
        int bad = 0;
        set_tri(0, 0, 10, 0, 0, 10);
        run_scan(17, 5);
        for (int x = 0; x <= 10; x++)
            for (int y = 0; y <= 10; y++)
                if (seen[0][x][y] != 1) bad++;
        checks++; if (n_hs[0] !== 121 || bad !== 0) begin errors++; $display("FAIL t5_pixels: got %0d (%0d bad) required 121 (0 bad)", n_hs[0], bad); end
        checks++; if (stab_err[0] + stab_err[2] !== 0) begin errors++; $display("FAIL t5_stable: got %0d changes required 0", stab_err[0] + stab_err[2]); end
        checks++; if (icnt[0] !== 36) begin errors++; $display("FAIL t5_inside_cnt: got %0d required 36", icnt[0]); end
        checks++; if (hs_last[0] !== 127) begin errors++; $display("FAIL t5_last_cycle: got %0d required 127", hs_last[0]); end
        checks++; if (degen[0] !== 1'b0) begin errors++; $display("FAIL t5_degenerate: got %b required 0", degen[0]); end
    endtask

    task automatic test_reset_mid();
        int cnt = 0;
        bit hit = 1'b0;
        set_tri(0, 0, 10, 0, 0, 10);
        pix_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            if (pv[0] === 1'b1) cnt++;
            if (cnt == 40) begin
                hit = 1'b1;
                checks++; if (px[0] !== 6 || py[0] !== 3) begin errors++; $display("FAIL t6_pixel40: got (%0d,%0d) required (6,3)", px[0], py[0]); end
                checks++; if (icnt[0] !== 20) begin errors++; $display("FAIL t6_cnt40: got %0d required 20", icnt[0]); end
                reset = 1'b1;
                #1;
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if ({busy[k], done[k], degen[k], pv[k], pin[k], px[k], py[k], icnt[k]} !== '0) begin
                        errors++;
                        $display("FAIL t6_async_reset dut%0d: busy=%b valid=%b x=%0d y=%0d cnt=%0d, required all 0",
                                 k, busy[k], pv[k], px[k], py[k], icnt[k]);
                    end
                end
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL t6_timeout: counted %0d pixels required 40", cnt); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 3'b000) begin errors++; $display("FAIL t6_idle_after_reset: got %b required 000", busy); end
    endtask

    task automatic test_abort();
        int cnt = 0;
        int bad = 0;
        bit hit = 1'b0;
        logic [2*CW:0] cv;
        set_tri(15, 15, 30, 0, 15, 0);
        pix_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            @(negedge clk);
            if (pv[0] === 1'b1) cnt++;
            if (cnt == 20) begin
                hit = 1'b1;
                abort = 1'b1;
                cv = icnt[0];
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL t6_abort_timeout: counted %0d pixels required 20", cnt); end
        @(negedge clk); abort = 1'b0;
        checks++; if (busy !== 3'b000 || pv !== 3'b000) begin errors++; $display("FAIL t6_abort_idle: busy=%b valid=%b required 000/000", busy, pv); end
        checks++; if (icnt[0] !== cv) begin errors++; $display("FAIL t6_abort_cnt_hold: got %0d required %0d", icnt[0], cv); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done !== 3'b000 || pv !== 3'b000) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL t6_abort_no_done: got %0d active cycles required 0", bad); end
        run_scan(MAXCYC, 0);
        checks++; if (first_x[0] !== 15 || first_y[0] !== 0) begin errors++; $display("FAIL t6_rescan_first: got (%0d,%0d) required (15,0)", first_x[0], first_y[0]); end
        checks++; if (n_hs[0] !== 256 || icnt[0] !== 91) begin errors++; $display("FAIL t6_rescan_counts: got %0d/%0d required 256/91", n_hs[0], icnt[0]); end
    endtask

    initial begin
        test_reset();
        test_right_triangle();
        test_offset_triangle();
        test_degenerate();
        test_stall();
        test_reset_mid();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
